// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-master arbiter for the shared data memory port. The CPU owns the port
//   by default; an external master (DMA / CP2) is granted the port only after
//   the CPU decoder acknowledges a freeze via hold/holdACK. Each external burst
//   is bounded to maxburst cycles and followed by a gap+1 cycle CPU window.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   cpu_we, cpu_a, cpu_d      CPU memory request
//   ext_req, ext_done         external master request / last-cycle flag
//   ext_we, ext_a, ext_d      external master memory request
//   holdACK                   CPU decoder confirms it is frozen
//   hold                      freeze request to the CPU decoder
//   ext_gnt                   external master owns the port this cycle
//   preempt                   one-cycle pulse: grant revoked by holdACK drop
//   dm_we, dm_a, dm_d         muxed memory port
module dmem_arbiter #(
  parameter int wide     = 32,
  parameter int maxburst = 16,
  parameter int gap      = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_we,
  input  logic [31:0]     cpu_a,
  input  logic [wide-1:0] cpu_d,
  input  logic            ext_req,
  input  logic            ext_done,
  input  logic            ext_we,
  input  logic [31:0]     ext_a,
  input  logic [wide-1:0] ext_d,
  input  logic            holdACK,
  output logic            hold,
  output logic            ext_gnt,
  output logic            preempt,
  output logic            dm_we,
  output logic [31:0]     dm_a,
  output logic [wide-1:0] dm_d
);

  typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} state_t;

  localparam logic [7:0] burst_last = 8'(maxburst - 1);
  localparam logic [7:0] gap_last   = 8'(gap);

  state_t     state;
  logic [7:0] bcnt;
  logic [7:0] gcnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bcnt    <= '0;
      gcnt    <= '0;
      preempt <= 1'b0;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE: if (ext_req) state <= REQ;
        REQ: begin
          // Abandoning the request wins over a late acknowledge.
          if (!ext_req) begin
            state <= IDLE;
          end else if (holdACK) begin
            state <= GRANT;
            bcnt  <= '0;
          end
        end
        GRANT: begin
          bcnt <= bcnt + 8'd1;
          // bcnt counts granted cycles from 0, so the last legal cycle is
          // maxburst-1 and a full burst is exactly maxburst cycles.
          if (!holdACK || ext_done || !ext_req || bcnt == burst_last) begin
            state   <= RELEASE;
            gcnt    <= '0;
            preempt <= !holdACK;
          end
        end
        RELEASE: begin
          // ext_req is ignored here: this is the CPU's guaranteed window.
          gcnt <= gcnt + 8'd1;
          if (gcnt == gap_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decodes of the registered state; no input reaches these directly.
  assign hold    = (state == REQ) || (state == GRANT);
  assign ext_gnt = (state == GRANT);

  // Port mux: cpu_we is fully blocked while the external master owns the port.
  assign dm_we = ext_gnt ? ext_we : cpu_we;
  assign dm_a  = ext_gnt ? ext_a  : cpu_a;
  assign dm_d  = ext_gnt ? ext_d  : cpu_d;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter: directed scenarios for reset,
//   single-write burst, forced release, abandon, preempt and reset mid-grant,
//   followed by randomized traffic compared every cycle against a reference
//   model that tracks ownership as "cycles granted so far" and "release
//   cycles remaining".
module tb_dmem_arbiter;

  localparam int wide     = 32;
  localparam int maxburst = 16;
  localparam int gap      = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            cpu_we;
  logic [31:0]     cpu_a;
  logic [wide-1:0] cpu_d;
  logic            ext_req;
  logic            ext_done;
  logic            ext_we;
  logic [31:0]     ext_a;
  logic [wide-1:0] ext_d;
  logic            holdACK;
  logic            hold;
  logic            ext_gnt;
  logic            preempt;
  logic            dm_we;
  logic [31:0]     dm_a;
  logic [wide-1:0] dm_d;

  int n_checks = 0;
  int n_fails  = 0;

  dmem_arbiter #(.wide(wide), .maxburst(maxburst), .gap(gap)) dut (
    .clk(clk), .rst(rst),
    .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_d(cpu_d),
    .ext_req(ext_req), .ext_done(ext_done),
    .ext_we(ext_we), .ext_a(ext_a), .ext_d(ext_d),
    .holdACK(holdACK),
    .hold(hold), .ext_gnt(ext_gnt), .preempt(preempt),
    .dm_we(dm_we), .dm_a(dm_a), .dm_d(dm_d)
  );

  always #5 clk = ~clk;

  // Small word-addressed memory driven by the arbiter's output port.
  logic [wide-1:0] ram [0:255];
  always @(posedge clk) if (dm_we) ram[dm_a[9:2]] <= dm_d;

  // Reference model: ownership described by counts, not by FSM states.
  bit m_hreq;    // request outstanding, CPU still owns the port
  int m_gcyc;    // granted cycles completed so far, -1 when not granted
  int m_rel;     // CPU fairness window cycles remaining
  bit m_pre;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hreq = 1'b0; m_gcyc = -1; m_rel = 0; m_pre = 1'b0;
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else if (m_rel > 0) begin
      m_rel--;
      m_pre = 1'b0;
    end else if (m_gcyc >= 0) begin
      m_gcyc++;
      m_pre = 1'b0;
      if (!holdACK || ext_done || !ext_req || m_gcyc == maxburst) begin
        m_gcyc = -1;
        m_rel  = gap + 1;
        m_pre  = !holdACK;
      end
    end else if (m_hreq) begin
      m_pre = 1'b0;
      if (!ext_req) m_hreq = 1'b0;
      else if (holdACK) begin
        m_hreq = 1'b0;
        m_gcyc = 0;
      end
    end else begin
      m_pre = 1'b0;
      if (ext_req) m_hreq = 1'b1;
    end
  endtask

  task automatic check_model();
    bit g;
    g = (m_gcyc >= 0);
    check("hold", hold, m_hreq || g);
    check("ext_gnt", ext_gnt, g);
    check("preempt", preempt, m_pre);
    check("dm_we", dm_we, g ? ext_we : cpu_we);
    check("dm_a", dm_a, g ? ext_a : cpu_a);
    check("dm_d", dm_d, g ? ext_d : cpu_d);
  endtask

  task automatic rand_data();
    cpu_we = 1'($urandom_range(0, 1));
    ext_we = 1'($urandom_range(0, 1));
    cpu_a  = $urandom;
    ext_a  = $urandom;
    cpu_d  = $urandom;
    ext_d  = $urandom;
  endtask

  // One clock cycle: check outputs mid-cycle, advance model at the edge,
  // then return at the falling edge with fresh random data fields.
  task automatic tick();
    #1 check_model();
    @(posedge clk);
    model_step();
    @(negedge clk);
    rand_data();
  endtask

  task automatic wait_gnt(input string tag);
    int i;
    i = 0;
    while (!ext_gnt && i < 50) begin
      tick();
      i++;
    end
    check(tag, ext_gnt, 1'b1);
  endtask

  int n;

  initial begin
    // Reset with random inputs for two edges.
    rand_data();
    rst = 1'b1; ext_req = 1'($urandom_range(0, 1));
    ext_done = 1'($urandom_range(0, 1)); holdACK = 1'($urandom_range(0, 1));
    @(posedge clk); model_reset();
    @(negedge clk); rand_data();
    tick();
    check("rst_hold", hold, 1'b0);
    check("rst_gnt", ext_gnt, 1'b0);
    check("rst_preempt", preempt, 1'b0);
    #1 check("rst_dm_a", dm_a, cpu_a);

    // Basic burst: one write with ext_done; concurrent cpu_we is blocked.
    rst = 1'b0; ext_req = 1'b1; holdACK = 1'b0; ext_done = 1'b0;
    tick();
    check("bb_hold", hold, 1'b1);
    tick(); tick();
    check("bb_no_gnt_yet", ext_gnt, 1'b0);
    holdACK = 1'b1;
    tick();
    ext_we = 1'b1; ext_a = 32'h40; ext_d = 32'hDEADBEEF; ext_done = 1'b1;
    cpu_we = 1'b1; cpu_a = 32'h40; cpu_d = 32'h11111111;
    check("bb_gnt", ext_gnt, 1'b1);
    tick();
    check("bb_ram", ram[8'h10], 32'hDEADBEEF);
    check("bb_gnt_drop", ext_gnt, 1'b0);
    check("bb_hold_drop", hold, 1'b0);
    ext_req = 1'b0; ext_done = 1'b0; holdACK = 1'b0;
    for (int i = 0; i < gap + 2; i++) tick();

    // Forced release: continuous request and acknowledge.
    ext_req = 1'b1; holdACK = 1'b1;
    wait_gnt("fr_wait1");
    n = 0;
    while (ext_gnt && n < 300) begin n++; tick(); end
    check("fr_burst_len", n, maxburst);
    n = 0;
    while (!hold && n < 300) begin n++; tick(); end
    check("fr_hold_low", n, gap + 2);
    n = 0;
    while (!ext_gnt && n < 300) begin n++; tick(); end
    check("fr_req_cycles", n, 1);
    n = 0;
    while (ext_gnt && n < 300) begin n++; tick(); end
    check("fr_burst_len2", n, maxburst);
    ext_req = 1'b0; holdACK = 1'b0;
    for (int i = 0; i < gap + 2; i++) tick();

    // Abandon in REQ before acknowledge.
    ext_req = 1'b1;
    tick();
    check("ab_hold", hold, 1'b1);
    ext_req = 1'b0;
    tick();
    check("ab_hold_drop", hold, 1'b0);
    check("ab_gnt", ext_gnt, 1'b0);
    holdACK = 1'b1;
    tick();
    check("ab_stay_idle", hold, 1'b0);
    holdACK = 1'b0;

    // Preempt: holdACK drops at grant cycle 5.
    ext_req = 1'b1; holdACK = 1'b1;
    wait_gnt("pe_wait");
    for (int i = 0; i < 4; i++) tick();
    holdACK = 1'b0;
    check("pe_gnt_c5", ext_gnt, 1'b1);
    tick();
    check("pe_gnt_drop", ext_gnt, 1'b0);
    check("pe_pulse", preempt, 1'b1);
    ext_req = 1'b0;
    tick();
    check("pe_pulse_end", preempt, 1'b0);
    for (int i = 0; i < gap; i++) tick();
    check("pe_idle_hold", hold, 1'b0);

    // Reset during grant cycle 3.
    ext_req = 1'b1; holdACK = 1'b1;
    wait_gnt("rg_wait");
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; ext_req = 1'b0;
    check("rg_gnt", ext_gnt, 1'b0);
    check("rg_hold", hold, 1'b0);
    #1 check("rg_dm_a", dm_a, cpu_a);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) ext_req = !ext_req;
      holdACK  = ($urandom_range(0, 3) != 0);
      ext_done = ($urandom_range(0, 9) == 0);
      rst      = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter for the shared data memory port. The CPU is the default owner. A second bus master (DMA engine or CP2 accelerator) gets the port only after the CPU is frozen through the control decoder's `hold`/`holdACK` handshake. The block sits between the datapath, the external master and `dmem`: it sequences the hold request, muxes `we/a/d` onto the memory and bounds each external burst for fairness.

## Interface
Parameters:
- `wide`, 32, data width of the memory port.
- `maxburst`, 16, maximum consecutive grant cycles; legal range 1..255.
- `gap`, 2, extra cycles the CPU owns the port after any release; legal range 0..255.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_we`  in  1  CPU memory write enable.
- `cpu_a`  in  32  CPU memory byte address.
- `cpu_d`  in  wide  CPU write data.
- `ext_req`  in  1  external master requests the port; held high for the whole burst.
- `ext_done`  in  1  external master's last cycle of its burst.
- `ext_we`  in  1  external master write enable.
- `ext_a`  in  32  external master address.
- `ext_d`  in  wide  external master write data.
- `holdACK`  in  1  CPU decoder confirms it is frozen.
- `hold`  out  1  freeze request to the CPU decoder.
- `ext_gnt`  out  1  the external master owns the port this cycle.
- `preempt`  out  1  one-cycle pulse: the grant was revoked because `holdACK` dropped.
- `dm_we`  out  1  memory write enable.
- `dm_a`  out  32  memory address.
- `dm_d`  out  wide  memory write data.

Read data from `dmem` fans out directly to both masters and does not pass through this block.

## Operation
- FSM states: IDLE, REQ, GRANT, RELEASE. There is an 8-bit burst counter `bcnt` and an 8-bit gap counter `gcnt`.
- Outputs are Moore decodes of the registered state:
  - `hold` = 1 in REQ and GRANT.
  - `ext_gnt` = 1 only in GRANT.
- Memory mux select is the registered `ext_gnt`:
  - `ext_gnt` = 1: `dm_a`/`dm_d` come from `ext_*`, and `dm_we` = `ext_we`.
  - `ext_gnt` = 0: `dm_a`/`dm_d` come from `cpu_*`, and `dm_we` = `cpu_we`.
  - `cpu_we` is fully blocked while `ext_gnt` = 1.
- IDLE: `ext_req` = 1 goes to REQ.
- REQ: the CPU still owns the port.
  - `ext_req` = 0 goes to IDLE (abandon); this has priority over `holdACK`.
  - Otherwise `holdACK` = 1 goes to GRANT and sets `bcnt` = 0.
- GRANT: `bcnt` increments every cycle. Exit to RELEASE on any of:
  - `holdACK` = 0 (preempt; also pulses `preempt`);
  - `ext_done` = 1;
  - `ext_req` = 0;
  - `bcnt` == `maxburst`-1 (forced release).
  - Priority for reporting: preempt over done/req over forced. The next state is RELEASE in every case.
- RELEASE: `gcnt` loads 0 on entry and increments each cycle. Go to IDLE when `gcnt` == `gap`, so RELEASE lasts `gap`+1 cycles. `ext_req` is ignored in RELEASE.
- A master still requesting at the end of RELEASE re-enters REQ from IDLE one cycle later. This is the CPU's fairness window.

## Timing
- Reset (`rst` = 1 at an edge) forces IDLE and clears `bcnt`, `gcnt` and `preempt`. After that edge, `hold` = `ext_gnt` = `preempt` = 0 and the mux selects the CPU.
- Reset overrides every state, including mid-GRANT. `ext_gnt` drops the cycle after the reset edge.
- `ext_req` sampled high at edge k (IDLE): `hold` = 1 from edge k.
- `holdACK` sampled high at edge m (REQ): `ext_gnt` = 1 from edge m.
- Minimum request-to-grant latency is 2 cycles.
- A write presented with `ext_done` in the same cycle completes, because `ext_gnt` is still 1 during that cycle. `ext_gnt` and `hold` drop at the next edge.
- Grant length with no done: exactly `maxburst` cycles.
- `preempt` is high for exactly the first cycle of RELEASE after a preempt exit; otherwise it is 0.
- There are no combinational paths from `ext_req`, `ext_done` or `holdACK` to any output. Only the data/address mux paths are combinational.

## Test plan
- Reset: drive `rst` for 2 cycles with random inputs -> `hold` = `ext_gnt` = `preempt` = 0 and `dm_a` == `cpu_a`.
- Basic burst: `ext_req` at cycle 0, `holdACK` raised 2 cycles after `hold`, master writes 0xDEADBEEF to 0x40 with `ext_done` -> `ext_gnt` high 1 cycle, `ram[0x10]` == 0xDEADBEEF, and `hold` low after 1 further edge. A `cpu_we` pulse during that cycle does not write.
- Forced release: `maxburst` = 16, `gap` = 2, `ext_req` held high, `holdACK` held high -> `ext_gnt` high exactly 16 cycles, low 3 cycles (RELEASE) plus 1 (IDLE), `hold` reasserts, and the pattern repeats.
- Abandon: `ext_req` drops in REQ before `holdACK` -> IDLE next edge, `ext_gnt` never asserted, `gcnt` unused.
- Preempt: `holdACK` drops at GRANT cycle 5 -> `ext_gnt` low next cycle, `preempt` = 1 for exactly one cycle, then IDLE after `gap`+1 cycles.
- Reset mid-GRANT at cycle 3 of a burst -> `ext_gnt` = `hold` = 0 after the reset edge, and the CPU owns the port.
